// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: Wishbone classic instruction prefetcher feeding a DEPTH-entry FIFO to decode.
module fetch_prefetch_buffer #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_addr_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [31:0]                inst_o,
  output logic [31:0]                pc_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  input  logic [31:0]                wbm_dat_i,
  input  logic                       wbm_ack_i,
  input  logic                       wbm_err_i,
  output logic                       wbm_cyc_o,
  output logic                       wbm_stb_o,
  output logic [31:0]                wbm_addr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, KILL, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, addr_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] pc_mem_q [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic [DEPTH-1:0] err_mem_q;
  logic done, push, pop;
  assign done    = wbm_ack_i | wbm_err_i;
  assign push    = state_q == REQ && done && !redirect_i;
  assign pop     = valid_o && ready_i && !redirect_i;
  assign count_d = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = redirect_i ? {redirect_addr_i[31:2], 2'b00} :
                 (push && !wbm_err_i) ? fetch_pc_q + 32'd4 : fetch_pc_q;
    case (state_q)
      IDLE: state_d = (redirect_i || count_q != FULL) ? REQ : IDLE;
      REQ:  state_d = redirect_i ? (done ? REQ : KILL) :
                      wbm_err_i ? HALT :
                      wbm_ack_i ? (count_d != FULL ? REQ : IDLE) : REQ;
      // A killed transfer must still complete; its result is simply dropped.
      KILL: state_d = done ? REQ : KILL;
      HALT: state_d = redirect_i ? REQ : HALT;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= {RESET_ADDR[31:2], 2'b00};
      addr_q     <= {RESET_ADDR[31:2], 2'b00};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (state_q == REQ) addr_q <= fetch_pc_q;
      wptr_q     <= redirect_i ? '0 : wptr_q + PW'(push);
      rptr_q     <= redirect_i ? '0 : rptr_q + PW'(pop);
      count_q    <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wptr_q]   <= fetch_pc_q;
      inst_mem_q[wptr_q] <= wbm_err_i ? NOP_INST : wbm_dat_i;
      err_mem_q[wptr_q]  <= wbm_err_i;
    end
  end
  assign valid_o    = count_q != '0;
  assign inst_o     = valid_o ? inst_mem_q[rptr_q] : NOP_INST;
  assign pc_o       = valid_o ? pc_mem_q[rptr_q] : 32'd0;
  assign err_o      = valid_o && err_mem_q[rptr_q];
  assign count_o    = count_q;
  assign wbm_cyc_o  = state_q == REQ || state_q == KILL;
  assign wbm_stb_o  = wbm_cyc_o;
  // During KILL the bus address stays on the squashed request while fetch_pc tracks the redirect.
  assign wbm_addr_o = state_q == KILL ? addr_q : fetch_pc_q;
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: directed table plus hand sequences against a simple wait-state Wishbone slave.
module tb_fetch_prefetch_buffer;
  logic clk = 1'b0;
  logic rst, redirect, ready, valid, err, ack, berr, cyc, stb, bad_en, err_en;
  logic [31:0] redirect_addr, inst, pc, dat, addr, err_addr;
  logic [2:0] count;
  int ws, wcnt;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_prefetch_buffer dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .ready_i(ready), .valid_o(valid), .inst_o(inst), .pc_o(pc), .err_o(err), .count_o(count),
    .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(berr),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_addr_o(addr)
  );

  logic hit;
  assign hit  = cyc && stb && wcnt >= ws;
  assign berr = hit && err_en && addr == err_addr;
  assign ack  = hit && !berr;
  assign dat  = bad_en ? 32'hDEAD_BEEF : ~addr;

  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else wcnt <= (!cyc || ack || berr) ? 0 : wcnt + 1;

  typedef struct {
    logic        ready;
    logic        cyc;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  count;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         3'd0};
    tbl[1] = '{1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000, 3'd1};
    tbl[2] = '{1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 3'd2};
    tbl[3] = '{1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0000, 3'd3};
    tbl[4] = '{1'b0, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0000, 3'd4};
    tbl[5] = '{1'b0, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0000, 3'd4};
    tbl[6] = '{1'b1, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0004, 3'd3};
    tbl[7] = '{1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0004, 3'd3};
    tbl[8] = '{1'b0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_0004, 3'd4};
    rst = 1'b1; redirect = 1'b0; redirect_addr = '0; ready = 1'b0;
    ws = 0; bad_en = 1'b0; err_en = 1'b0; err_addr = 32'h8000_0008;
    repeat (2) step();
    chk("rst_valid", valid, 0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_pc", pc, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_addr", addr, 32'h8000_0000);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      ready = tbl[i].ready;
      step();
      chk($sformatf("t%0d_cyc", i), cyc, tbl[i].cyc);
      chk($sformatf("t%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), valid, tbl[i].valid);
      chk($sformatf("t%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("t%0d_count", i), count, tbl[i].count);
      chk($sformatf("t%0d_inst", i), inst, tbl[i].valid ? ~tbl[i].pc : 32'h13);
    end

    // streaming: push and pop every cycle, pointers wrap several times
    ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h8000_1000;
    step();
    chk("b_count", count, 0);
    chk("b_valid", valid, 0);
    chk("b_addr", addr, 32'h8000_1000);
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("b%0d_pc", i), pc, 32'h8000_1000 + 32'(4 * i));
      chk($sformatf("b%0d_count", i), count, 1);
      chk($sformatf("b%0d_inst", i), inst, ~(32'h8000_1000 + 32'(4 * i)));
    end
    ready = 1'b0;
    repeat (6) step();
    chk("b_full_count", count, 4);
    chk("b_full_cyc", cyc, 0);

    // redirect during a wait-stated fetch: squash and hold the bus
    ws = 3; redirect = 1'b1; redirect_addr = 32'h8000_0400;
    step();
    redirect = 1'b0;
    chk("c_cyc0", cyc, 1);
    chk("c_addr0", addr, 32'h8000_0400);
    step();
    redirect = 1'b1; redirect_addr = 32'h8000_0103; bad_en = 1'b1;
    step();
    redirect = 1'b0;
    chk("c_count", count, 0);
    chk("c_valid", valid, 0);
    chk("c_cyc_kill", cyc, 1);
    chk("c_addr_kill", addr, 32'h8000_0400);
    step();
    chk("c_cyc_ack", cyc, 1);
    chk("c_ack", ack, 1);
    step();
    bad_en = 1'b0;
    chk("c_cyc_new", cyc, 1);
    chk("c_addr_new", addr, 32'h8000_0100);
    chk("c_count_new", count, 0);
    begin
      int k = 0;
      while (!valid && k < 10) begin step(); k++; end
    end
    chk("c_valid_wait", valid, 1);
    chk("c_pc", pc, 32'h8000_0100);
    chk("c_inst", inst, ~32'h8000_0100);

    // redirect in the same cycle as ack
    ws = 0; redirect = 1'b1; redirect_addr = 32'h8000_0600;
    step();
    chk("d_ack", ack, 1);
    chk("d_addr0", addr, 32'h8000_0600);
    redirect_addr = 32'h8000_0700;
    step();
    redirect = 1'b0;
    chk("d_count", count, 0);
    chk("d_valid", valid, 0);
    chk("d_addr", addr, 32'h8000_0700);
    step();
    chk("d_pc", pc, 32'h8000_0700);
    chk("d_count1", count, 1);

    // bus error on the third fetch halts fetching until redirect
    err_en = 1'b1; redirect = 1'b1; redirect_addr = 32'h8000_0000;
    step();
    redirect = 1'b0;
    repeat (3) step();
    chk("e_count", count, 3);
    chk("e_cyc_halt", cyc, 0);
    chk("e_pc0", pc, 32'h8000_0000);
    chk("e_err0", err, 0);
    ready = 1'b1;
    step();
    chk("e_pc1", pc, 32'h8000_0004);
    step();
    ready = 1'b0;
    chk("e_pc2", pc, 32'h8000_0008);
    chk("e_inst2", inst, 32'h13);
    chk("e_err2", err, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("e_halt%0d_cyc", i), cyc, 0);
    end
    err_en = 1'b0; redirect = 1'b1; redirect_addr = 32'h8000_0200;
    step();
    redirect = 1'b0;
    chk("e_res_cyc", cyc, 1);
    chk("e_res_addr", addr, 32'h8000_0200);
    chk("e_res_count", count, 0);
    step();
    chk("e_res_pc", pc, 32'h8000_0200);

    // asynchronous reset mid-transfer
    ws = 3;
    step();
    chk("f_cyc_pre", cyc, 1);
    #2 rst = 1'b1;
    #1;
    chk("f_cyc_async", cyc, 0);
    chk("f_stb_async", stb, 0);
    chk("f_count_async", count, 0);
    step();
    rst = 1'b0;
    step();
    chk("f_cyc_post", cyc, 1);
    chk("f_addr_post", addr, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
